rtc_hms_clock: RTL and testbench

Parametrised real-time HH:MM:SS clock with a built-in seconds prescaler, a loadable time-set port, 12/24-hour display mode and a 6-digit multiplexed seven-segment driver. It replaces the fixed-frequency 24-hour clock on the lab board. It sits between the board oscillator and the seven-segment/LED pins, and exposes BCD time and a day carry to downstream logic.

---
 rtl/rtc_pkg.sv | 84 ++++++++
 rtl/bcd_mod_counter.sv | 40 ++++
 rtl/rtc_hms_clock.sv | 254 +++++++++++++++++++++++++
 tb/tb_rtc_hms_clock.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_pkg
// Description : Shared BCD types, limits, seven-segment patterns and helper
//               functions for the rtc_hms_clock block.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd_pair_t;

  localparam bcd_pair_t  c_hh_max    = 8'h23;
  localparam bcd_pair_t  c_ms_max    = 8'h59;
  localparam bcd_digit_t c_digit_max = 4'h9;

  // Segment order abcdefg, bit 6 = a, active-high
  localparam logic [6:0] c_seg_0     = 7'b1111110;
  localparam logic [6:0] c_seg_1     = 7'b0110000;
  localparam logic [6:0] c_seg_2     = 7'b1101101;
  localparam logic [6:0] c_seg_3     = 7'b1111001;
  localparam logic [6:0] c_seg_4     = 7'b0110011;
  localparam logic [6:0] c_seg_5     = 7'b1011011;
  localparam logic [6:0] c_seg_6     = 7'b1011111;
  localparam logic [6:0] c_seg_7     = 7'b1110000;
  localparam logic [6:0] c_seg_8     = 7'b1111111;
  localparam logic [6:0] c_seg_9     = 7'b1111011;
  localparam logic [6:0] c_seg_blank = 7'b0000000;

  // Both nibbles must be decimal and the pair must not exceed max_v
  function automatic logic bcd_valid(input bcd_pair_t v, input bcd_pair_t max_v);
    return (v[7:4] <= c_digit_max) && (v[3:0] <= c_digit_max) && (v <= max_v);
  endfunction

  // Next value of a two-digit BCD counter that wraps max_v -> 00
  function automatic bcd_pair_t bcd_inc(input bcd_pair_t v, input bcd_pair_t max_v);
    bcd_pair_t r;
    if (v == max_v) begin
      r = 8'h00;
    end else if (v[3:0] == c_digit_max) begin
      r = {v[7:4] + 4'd1, 4'h0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // 24-hour BCD hours to 12-hour BCD hours (00 -> 12, 13..23 -> hh-12)
  function automatic bcd_pair_t to_12h(input bcd_pair_t hh24);
    bcd_pair_t r;
    r = hh24;
    if (hh24 == 8'h00) begin
      r = 8'h12;
    end else if ((hh24 >= 8'h13) && (hh24 <= 8'h19)) begin
      r = {4'h0, hh24[3:0] - 4'd2};
    end else if ((hh24 >= 8'h20) && (hh24 <= 8'h21)) begin
      r = {4'h0, hh24[3:0] + 4'd8};
    end else if (hh24 >= 8'h22) begin
      r = {4'h1, hh24[3:0] - 4'd2};
    end
    return r;
  endfunction

  // Decimal digit to segment pattern; anything else is dark
  function automatic logic [6:0] seg_decode(input bcd_digit_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = c_seg_0;
      4'd1:    s = c_seg_1;
      4'd2:    s = c_seg_2;
      4'd3:    s = c_seg_3;
      4'd4:    s = c_seg_4;
      4'd5:    s = c_seg_5;
      4'd6:    s = c_seg_6;
      4'd7:    s = c_seg_7;
      4'd8:    s = c_seg_8;
      4'd9:    s = c_seg_9;
      default: s = c_seg_blank;
    endcase
    return s;
  endfunction

endpackage : rtc_pkg
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_mod_counter
// Description : Two-digit BCD counter wrapping MAX -> 00 with synchronous
//               load. wrap flags the increment that rolls over so counters
//               can be chained in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_mod_counter
  import rtc_pkg::*;
#(
  parameter bcd_pair_t MAX = 8'h59
) (
  input  logic      clk_in,
  input  logic      reset,
  input  logic      inc,
  input  logic      load,
  input  bcd_pair_t load_val,
  output bcd_pair_t value,
  output logic      wrap
);

  bcd_pair_t r_value;

  // Load beats increment; otherwise step in BCD
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_value <= 8'h00;
    end else if (load) begin
      r_value <= load_val;
    end else if (inc) begin
      r_value <= bcd_inc(r_value, MAX);
    end
  end

  assign value = r_value;
  assign wrap  = inc && !load && (r_value == MAX);

endmodule : bcd_mod_counter
`default_nettype wire

// File: rtl/rtc_hms_clock.sv
`default_nettype none
// ============================================================================
// Module      : rtc_hms_clock
// Description : HH:MM:SS real-time clock with seconds prescaler, time-set
//               port, 12/24-hour display and 6-digit multiplexed 7-seg scan.
//               Optional alarm enabled by defining RTC_HMS_CLOCK_ALARM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_hms_clock
  import rtc_pkg::*;
#(
  parameter int CLK_HZ   = 10_000_000,
  parameter int SCAN_DIV = 8192
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       enable,
  input  logic       mode_12h,
  input  logic       set_strobe,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  output logic       set_err,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_carry,
  output logic [2:0] seg7_sel,
  output logic [6:0] seg7_out,
  output logic       dpt,
  output logic       led_com
`ifdef RTC_HMS_CLOCK_ALARM_EN
  ,
  input  logic       alarm_set,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_ack,
  output logic       alarm_ring
`endif
);

  localparam int c_presc_w = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int c_scan_w  = $clog2(SCAN_DIV + 1);
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(CLK_HZ - 1);
  localparam logic [c_scan_w-1:0]  c_scan_last  = c_scan_w'(SCAN_DIV - 1);
  localparam logic [2:0]           c_sel_first  = 3'd5;

  logic [c_presc_w-1:0] r_presc;
  logic [c_scan_w-1:0]  r_scan_div;
  logic [2:0]           r_sel;
  logic                 r_sec_tick;
  logic                 r_day_carry;
  logic                 r_set_err;
  logic                 r_pm;

  bcd_pair_t w_hh;
  bcd_pair_t w_mm;
  bcd_pair_t w_ss;
  bcd_pair_t w_hh_next;
  bcd_pair_t w_hh_disp;
  bcd_digit_t w_digit;
  logic      w_ss_wrap;
  logic      w_mm_wrap;
  logic      w_hh_wrap;
  logic      w_set_ok;
  logic      w_load;
  logic      w_presc_last;
  logic      w_advance;
  logic      w_scan_last;
  logic      w_blank;
  logic      w_dpt;
  logic [6:0] w_seg;

  assign w_set_ok     = bcd_valid(set_hh, c_hh_max) && bcd_valid(set_mm, c_ms_max)
                        && bcd_valid(set_ss, c_ms_max);
  assign w_load       = set_strobe && w_set_ok;
  assign w_presc_last = (r_presc == c_presc_last);
  // Any strobe, legal or not, swallows a coincident advance
  assign w_advance    = enable && !set_strobe && w_presc_last;

  // Seconds prescaler: cleared by a legal load, held by an illegal one
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_load) begin
      r_presc <= '0;
    end else if (enable && !set_strobe) begin
      r_presc <= w_presc_last ? '0 : r_presc + c_presc_w'(1);
    end
  end

  bcd_mod_counter #(.MAX(c_ms_max)) u_ss (
    .clk_in   (clk_in),
    .reset    (reset),
    .inc      (w_advance),
    .load     (w_load),
    .load_val (set_ss),
    .value    (w_ss),
    .wrap     (w_ss_wrap)
  );

  bcd_mod_counter #(.MAX(c_ms_max)) u_mm (
    .clk_in   (clk_in),
    .reset    (reset),
    .inc      (w_ss_wrap),
    .load     (w_load),
    .load_val (set_mm),
    .value    (w_mm),
    .wrap     (w_mm_wrap)
  );

  bcd_mod_counter #(.MAX(c_hh_max)) u_hh (
    .clk_in   (clk_in),
    .reset    (reset),
    .inc      (w_mm_wrap),
    .load     (w_load),
    .load_val (set_hh),
    .value    (w_hh),
    .wrap     (w_hh_wrap)
  );

  // Hours value the counter will hold after this edge, used to register pm
  assign w_hh_next = w_load ? set_hh : (w_mm_wrap ? bcd_inc(w_hh, c_hh_max) : w_hh);

  // Registered status pulses and pm flag
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_sec_tick  <= 1'b0;
      r_day_carry <= 1'b0;
      r_set_err   <= 1'b0;
      r_pm        <= 1'b0;
    end else begin
      r_sec_tick  <= w_advance;
      r_day_carry <= w_hh_wrap;
      r_set_err   <= set_strobe && !w_set_ok;
      r_pm        <= (w_hh_next >= 8'h12);
    end
  end

  assign w_scan_last = (r_scan_div == c_scan_last);

  // Digit scan 5,4,3,2,1,0,5,... holding each for SCAN_DIV cycles
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_scan_div <= '0;
      r_sel      <= c_sel_first;
    end else if (w_scan_last) begin
      r_scan_div <= '0;
      r_sel      <= (r_sel == 3'd0) ? c_sel_first : r_sel - 3'd1;
    end else begin
      r_scan_div <= r_scan_div + c_scan_w'(1);
    end
  end

  // Active digit selection, leading-zero blanking and decimal points
  always_comb begin
    w_hh_disp = mode_12h ? to_12h(w_hh) : w_hh;
    w_digit   = 4'hF;
    w_blank   = 1'b0;
    w_dpt     = 1'b0;
    case (r_sel)
      3'd5: begin
        w_digit = w_ss[3:0];
        w_dpt   = mode_12h && r_pm;
      end
      3'd4: w_digit = w_ss[7:4];
      3'd3: begin
        w_digit = w_mm[3:0];
        w_dpt   = 1'b1;
      end
      3'd2: w_digit = w_mm[7:4];
      3'd1: begin
        w_digit = w_hh_disp[3:0];
        w_dpt   = 1'b1;
      end
      3'd0: begin
        w_digit = w_hh_disp[7:4];
        w_blank = mode_12h && (w_hh_disp[7:4] == 4'h0);
      end
      default: w_digit = 4'hF;
    endcase
    w_seg = w_blank ? c_seg_blank : seg_decode(w_digit);
  end

  assign hh        = w_hh;
  assign mm        = w_mm;
  assign ss        = w_ss;
  assign pm        = r_pm;
  assign sec_tick  = r_sec_tick;
  assign day_carry = r_day_carry;
  assign set_err   = r_set_err;
  assign seg7_sel  = r_sel;
  assign seg7_out  = w_seg;
  assign dpt       = w_dpt;
  assign led_com   = 1'b1;

`ifdef RTC_HMS_CLOCK_ALARM_EN
  localparam logic [5:0] c_ring_last = 6'd59;

  bcd_pair_t  r_alarm_hh;
  bcd_pair_t  r_alarm_mm;
  logic       r_armed;
  logic       r_ring;
  logic [5:0] r_ring_cnt;
  logic       w_alarm_ok;
  logic       w_alarm_hit;

  assign w_alarm_ok  = bcd_valid(alarm_hh, c_hh_max) && bcd_valid(alarm_mm, c_ms_max);
  // A seconds wrap lands on hh:mm:00 of the following minute
  assign w_alarm_hit = r_armed && w_ss_wrap
                       && (bcd_inc(w_mm, c_ms_max) == r_alarm_mm)
                       && ((w_mm_wrap ? bcd_inc(w_hh, c_hh_max) : w_hh) == r_alarm_hh);

  // Alarm time register, armed by the first legal set
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_alarm_hh <= 8'h00;
      r_alarm_mm <= 8'h00;
      r_armed    <= 1'b0;
    end else if (alarm_set && w_alarm_ok) begin
      r_alarm_hh <= alarm_hh;
      r_alarm_mm <= alarm_mm;
      r_armed    <= 1'b1;
    end
  end

  // Ring flag: ack wins, otherwise auto-clears after 60 further advances
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_ring     <= 1'b0;
      r_ring_cnt <= '0;
    end else if (alarm_ack) begin
      r_ring     <= 1'b0;
      r_ring_cnt <= '0;
    end else if (w_alarm_hit) begin
      r_ring     <= 1'b1;
      r_ring_cnt <= '0;
    end else if (r_ring && w_advance) begin
      if (r_ring_cnt == c_ring_last) begin
        r_ring     <= 1'b0;
        r_ring_cnt <= '0;
      end else begin
        r_ring_cnt <= r_ring_cnt + 6'd1;
      end
    end
  end

  assign alarm_ring = r_ring;
`endif

endmodule : rtc_hms_clock
`default_nettype wire

// File: tb/tb_rtc_hms_clock.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_hms_clock
// Description : Directed self-checking bench for rtc_hms_clock (default
//               build, CLK_HZ=4, SCAN_DIV=2) with a scoreboard of expected
//               times and tick pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_hms_clock;

  localparam int CLK_HZ   = 4;
  localparam int SCAN_DIV = 2;

  localparam logic [6:0] c_p0 = 7'b1111110;
  localparam logic [6:0] c_p1 = 7'b0110000;
  localparam logic [6:0] c_p2 = 7'b1101101;
  localparam logic [6:0] c_p3 = 7'b1111001;
  localparam logic [6:0] c_p5 = 7'b1011011;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       enable;
  logic       mode_12h;
  logic       set_strobe;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic [7:0] set_ss;
  logic       set_err;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       pm;
  logic       sec_tick;
  logic       day_carry;
  logic [2:0] seg7_sel;
  logic [6:0] seg7_out;
  logic       dpt;
  logic       led_com;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [23:0] time_q[$];
  logic [1:0]  tick_q[$];

  rtc_hms_clock #(.CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .enable     (enable),
    .mode_12h   (mode_12h),
    .set_strobe (set_strobe),
    .set_hh     (set_hh),
    .set_mm     (set_mm),
    .set_ss     (set_ss),
    .set_err    (set_err),
    .hh         (hh),
    .mm         (mm),
    .ss         (ss),
    .pm         (pm),
    .sec_tick   (sec_tick),
    .day_carry  (day_carry),
    .seg7_sel   (seg7_sel),
    .seg7_out   (seg7_out),
    .dpt        (dpt),
    .led_com    (led_com)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scan model: sel starts at 5 and steps down every SCAN_DIV edges since reset release
  function automatic logic [2:0] exp_sel(input int c);
    return 3'(5 - ((c / SCAN_DIV) % 6));
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
    chk("scan_sel", {29'd0, seg7_sel}, {29'd0, exp_sel(cyc)});
  endtask

  task automatic push_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    time_q.push_back({h, m, s});
  endtask

  task automatic pop_time(input string tag);
    if (time_q.size() == 0) begin
      chk("sb_time_empty", 32'd1, 32'd0);
    end else begin
      chk(tag, {8'd0, hh, mm, ss}, {8'd0, time_q.pop_front()});
    end
  endtask

  task automatic push_ticks(input int n, input int adv_at, input int day_at);
    for (int k = 1; k <= n; k++) begin
      tick_q.push_back({(adv_at > 0) && (k % adv_at == 0), k == day_at});
    end
  endtask

  task automatic run_ticks(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      step();
      if (tick_q.size() == 0) begin
        chk("sb_tick_empty", 32'd1, 32'd0);
      end else begin
        chk(tag, {30'd0, sec_tick, day_carry}, {30'd0, tick_q.pop_front()});
      end
    end
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_hh     = h;
    set_mm     = m;
    set_ss     = s;
    set_strobe = 1'b1;
    step();
    set_strobe = 1'b0;
  endtask

  task automatic wait_sel(input logic [2:0] s);
    int i;
    i = 0;
    while ((seg7_sel !== s) && (i < 16)) begin
      step();
      i++;
    end
    chk("wait_sel", {29'd0, seg7_sel}, {29'd0, s});
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    mode_12h   = 1'b0;
    set_strobe = 1'b0;
    set_hh     = 8'h00;
    set_mm     = 8'h00;
    set_ss     = 8'h00;
    #12;

    // Reset state
    chk("rst_time",     {8'd0, hh, mm, ss}, 32'h0000_0000);
    chk("rst_sec_tick", {31'd0, sec_tick},  32'd0);
    chk("rst_day",      {31'd0, day_carry}, 32'd0);
    chk("rst_set_err",  {31'd0, set_err},   32'd0);
    chk("rst_pm",       {31'd0, pm},        32'd0);
    chk("rst_sel",      {29'd0, seg7_sel},  32'd5);
    chk("rst_seg",      {25'd0, seg7_out},  {25'd0, c_p0});
    chk("rst_dpt",      {31'd0, dpt},       32'd0);
    chk("led_com",      {31'd0, led_com},   32'd1);

    @(posedge clk_in);
    #1;
    reset = 1'b0;
    cyc   = 0;

    // Free run from reset: ticks after edges 4, 8, 12
    push_ticks(12, 4, 0);
    run_ticks(12, "run_tick");
    chk("run_ss03", {8'd0, hh, mm, ss}, 32'h0000_0003);

    // Day wrap
    push_time(8'h23, 8'h59, 8'h58);
    load(8'h23, 8'h59, 8'h58);
    pop_time("load_235958");
    push_ticks(4, 4, 0);
    run_ticks(4, "wrap_tick_a");
    chk("t_235959", {8'd0, hh, mm, ss}, 32'h0023_5959);
    push_ticks(4, 4, 4);
    run_ticks(4, "wrap_tick_b");
    chk("t_000000", {8'd0, hh, mm, ss}, 32'h0000_0000);

    // Strobe coincident with an advance discards the advance
    step();
    step();
    step();
    push_time(8'h01, 8'h02, 8'h03);
    load(8'h01, 8'h02, 8'h03);
    chk("adv_discarded", {31'd0, sec_tick}, 32'd0);
    pop_time("load_010203");
    push_ticks(4, 4, 0);
    run_ticks(4, "post_load_tick");
    chk("t_010204", {8'd0, hh, mm, ss}, 32'h0001_0204);

    // Illegal loads leave time alone and pulse set_err
    enable = 1'b0;
    push_time(8'h01, 8'h02, 8'h04);
    load(8'h12, 8'h60, 8'h00);
    chk("err_mm60", {31'd0, set_err}, 32'd1);
    pop_time("keep_mm60");
    step();
    chk("err_clear", {31'd0, set_err}, 32'd0);
    push_time(8'h01, 8'h02, 8'h04);
    load(8'h1A, 8'h00, 8'h00);
    chk("err_hh1a", {31'd0, set_err}, 32'd1);
    pop_time("keep_hh1a");
    push_time(8'h12, 8'h34, 8'h56);
    load(8'h12, 8'h34, 8'h56);
    chk("ok_no_err", {31'd0, set_err}, 32'd0);
    pop_time("load_123456");
    enable = 1'b1;
    push_ticks(4, 4, 0);
    run_ticks(4, "restart_tick");
    chk("t_123457", {8'd0, hh, mm, ss}, 32'h0012_3457);

    // 12-hour display at 00:05:00
    enable = 1'b0;
    push_time(8'h00, 8'h05, 8'h00);
    load(8'h00, 8'h05, 8'h00);
    pop_time("load_000500");
    mode_12h = 1'b1;
    chk("pm_midnight", {31'd0, pm}, 32'd0);
    wait_sel(3'd0);
    chk("h12_tens", {25'd0, seg7_out}, {25'd0, c_p1});
    chk("h12_tens_dp", {31'd0, dpt}, 32'd0);
    wait_sel(3'd1);
    chk("h12_units", {25'd0, seg7_out}, {25'd0, c_p2});
    chk("sep_dp1", {31'd0, dpt}, 32'd1);

    // 13:05:00 shows " 1" with pm marked
    push_time(8'h13, 8'h05, 8'h00);
    load(8'h13, 8'h05, 8'h00);
    pop_time("load_130500");
    chk("pm_13", {31'd0, pm}, 32'd1);
    wait_sel(3'd0);
    chk("h13_blank", {25'd0, seg7_out}, 32'd0);
    mode_12h = 1'b0;
    #1;
    chk("h13_tens_24", {25'd0, seg7_out}, {25'd0, c_p1});
    mode_12h = 1'b1;
    wait_sel(3'd1);
    chk("h13_units", {25'd0, seg7_out}, {25'd0, c_p1});
    mode_12h = 1'b0;
    #1;
    chk("h13_units_24", {25'd0, seg7_out}, {25'd0, c_p3});
    mode_12h = 1'b1;
    wait_sel(3'd5);
    chk("ss_units_seg", {25'd0, seg7_out}, {25'd0, c_p0});
    chk("pm_dp", {31'd0, dpt}, 32'd1);
    mode_12h = 1'b0;
    #1;
    chk("pm_dp_24", {31'd0, dpt}, 32'd0);
    wait_sel(3'd3);
    chk("mm_units_seg", {25'd0, seg7_out}, {25'd0, c_p5});
    chk("sep_dp3", {31'd0, dpt}, 32'd1);

    // Freeze mid-second, then resume without phase loss
    enable = 1'b1;
    push_time(8'h00, 8'h00, 8'h00);
    load(8'h00, 8'h00, 8'h00);
    pop_time("load_zero");
    step();
    step();
    enable = 1'b0;
    push_ticks(10, 0, 0);
    run_ticks(10, "frozen_tick");
    chk("frozen_time", {8'd0, hh, mm, ss}, 32'h0000_0000);
    enable = 1'b1;
    push_ticks(2, 2, 0);
    run_ticks(2, "resume_tick");
    chk("t_000001", {8'd0, hh, mm, ss}, 32'h0000_0001);

    // Asynchronous reset mid-second
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_time", {8'd0, hh, mm, ss}, 32'h0000_0000);
    chk("arst_sel",  {29'd0, seg7_sel}, 32'd5);
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    cyc   = 0;
    push_ticks(4, 4, 0);
    run_ticks(4, "arst_tick");
    chk("arst_t_000001", {8'd0, hh, mm, ss}, 32'h0000_0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rtc_hms_clock
`default_nettype wire
